serial_char_tx: RTL

SERIAL_CHAR_TX -- requirements
Module: serial_char_tx

---
 rtl/serial_link_pkg.sv | 23 ++
 rtl/bit_timer.sv | 34 +++
 rtl/serial_char_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial character link (transmitter and receiver).
package serial_link_pkg;

  // Frame sequencer states, common to both ends of the link.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } link_state_e;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;  // line level when idle, also the stop bit
  localparam logic START_LEVEL = 1'b0;

  // Even parity: XOR of the data bits, so the total count of ones including
  // the parity bit is even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and strobes at the end of
// each period. Held at zero while restart is high; it also wraps to zero at
// every period end, so each state entry begins a fresh period.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done,      // last cycle of the current bit period
  output logic bit_near_done  // cycle just before the last one
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // Period counter: cleared by restart or at period end, else increments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done      = (cnt == LAST);
  assign bit_near_done = (cnt == PRE);

endmodule

// File: rtl/serial_char_tx.sv
// Serial character transmitter: a one-byte holding register fed by the
// processor, and a frame sequencer that shifts out start, 8 data bits LSB
// first, optional even parity, and stop. All outputs are registered.
//
// Handshake: a byte is offered by pulsing load with parallel_out valid. It is
// accepted when the holding register is empty, or in the same cycle the held
// byte moves into the shift register; any other load is dropped and sets the
// sticky overrun flag. hold_full acts as the "not ready" indication.
module serial_char_tx
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] parallel_out,
  input  logic       load,
  input  logic       transmit_enable,
  output logic       tx,
  output logic       char_sent,
  output logic       busy,
  output logic       hold_full,
  output logic       overrun
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  link_state_e          state;
  logic [DATA_BITS-1:0] hold_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 parity_bit;

  logic bit_done;
  logic bit_near_done;
  logic take;
  logic load_ok;

  // The timer idles at zero; it starts counting on entry to START.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .restart      (state == IDLE),
    .bit_done     (bit_done),
    .bit_near_done(bit_near_done)
  );

  // Held byte moves to the shift register either from IDLE or at the very
  // end of a stop bit, which gives back-to-back frames with no gap.
  assign take    = hold_full && transmit_enable &&
                   ((state == IDLE) || ((state == STOP) && bit_done));
  assign load_ok = load && (!hold_full || take);

  // Holding register and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load_ok) begin
        hold_reg  <= parallel_out;
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      if (load && !load_ok) begin
        overrun <= 1'b1;
      end
    end
  end

  // Frame sequencer with registered line, busy and char_sent outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      char_sent  <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
    end else begin
      // High exactly during the final cycle of the stop bit.
      char_sent <= (state == STOP) && bit_near_done;
      if (take) begin
        state      <= START;
        tx         <= START_LEVEL;
        busy       <= 1'b1;
        shift_reg  <= hold_reg;
        parity_bit <= even_parity(hold_reg);
        bit_idx    <= '0;
      end else begin
        case (state)
          IDLE: begin
            tx   <= IDLE_LEVEL;
            busy <= 1'b0;
          end
          START: begin
            if (bit_done) begin
              state <= DATA;
              tx    <= shift_reg[0];
            end
          end
          DATA: begin
            if (bit_done) begin
              if (bit_idx == LAST_IDX) begin
                if (PARITY_EN) begin
                  state <= PARITY;
                  tx    <= parity_bit;
                end else begin
                  state <= STOP;
                  tx    <= IDLE_LEVEL;
                end
              end else begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                tx        <= shift_reg[1];
              end
            end
          end
          PARITY: begin
            if (bit_done) begin
              state <= STOP;
              tx    <= IDLE_LEVEL;
            end
          end
          STOP: begin
            if (bit_done) begin
              state <= IDLE;
              tx    <= IDLE_LEVEL;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= IDLE_LEVEL;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
